// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator for the FIR output stream: sums blocks of 2^LOG2_DECIM samples,
// scales and saturates each sum, and queues results in a small FIFO behind a valid/ready port.
module fir_decimator #(
    parameter int BW_in      = 8,
    parameter int LOG2_DECIM = 2,
    parameter int SHIFT      = 1,
    parameter int BW_out     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [BW_in-1:0]  y_in,
    input  logic                     sync,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [BW_out-1:0] out_data,
    output logic [3:0]               fifo_level,
    output logic                     saturated,
    output logic                     overrun
);

    localparam int BW_ACC = BW_in + LOG2_DECIM;
    localparam int SW     = ((BW_ACC > BW_out) ? BW_ACC : BW_out) + 1;
    localparam int PW     = $clog2(FIFO_DEPTH);

    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;
    localparam logic [3:0]            LVL_FULL = 4'(FIFO_DEPTH);
    localparam logic signed [SW-1:0]  OUT_MAX  = {{(SW-BW_out+1){1'b0}}, {(BW_out-1){1'b1}}};
    localparam logic signed [SW-1:0]  OUT_MIN  = ~OUT_MAX;

    // Comparisons run one bit wider than both accumulator and output so the clip bounds always fit.
    function automatic logic signed [SW-1:0] widen(input logic signed [BW_ACC-1:0] v);
        return {{(SW-BW_ACC){v[BW_ACC-1]}}, v};
    endfunction

    function automatic logic clips(input logic signed [BW_ACC-1:0] v);
        return (widen(v) > OUT_MAX) || (widen(v) < OUT_MIN);
    endfunction

    function automatic logic signed [BW_out-1:0] saturate(input logic signed [BW_ACC-1:0] v);
        logic signed [SW-1:0] w;
        w = widen(v);
        if (w > OUT_MAX) return OUT_MAX[BW_out-1:0];
        if (w < OUT_MIN) return OUT_MIN[BW_out-1:0];
        return w[BW_out-1:0];
    endfunction

    logic signed [BW_ACC-1:0] r_acc;
    logic [LOG2_DECIM-1:0]    r_cnt;
    logic signed [BW_out-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [3:0]               r_level;
    logic                     r_sat;
    logic                     r_ovr;

    logic signed [BW_ACC-1:0] w_y_ext;
    logic signed [BW_ACC-1:0] w_sum;
    logic signed [BW_ACC-1:0] w_scaled;
    logic signed [BW_out-1:0] w_result;
    logic                     w_dump;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;

    assign w_y_ext  = {{LOG2_DECIM{y_in[BW_in-1]}}, y_in};
    assign w_sum    = r_acc + w_y_ext;
    assign w_scaled = w_sum >>> SHIFT;
    assign w_result = saturate(w_scaled);

    assign w_dump = in_valid && !sync && (r_cnt == CNT_LAST);
    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = (r_level != 4'd0) && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = w_dump && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_sat    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (sync) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (in_valid) begin
                if (r_cnt == CNT_LAST) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (clips(w_scaled)) r_sat <= 1'b1;
                    if (!w_push) r_ovr <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 4'd1;
                2'b01:   r_level <= r_level - 4'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries data only; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_result;
    end

    assign out_valid  = (r_level != 4'd0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign saturated  = r_sat;
    assign overrun    = r_ovr;

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 4-tap FIR. Consumes the FIR's signed 8-bit output stream and integrates blocks of 2^LOG2_DECIM samples (integrate-and-dump).
- Scales each block sum by an arithmetic right shift, saturates it to BW_out and queues it in a small FIFO.
- Results leave through a valid/ready port, so a slow consumer (pin mux, serializer) can take them without stalling the FIR.

Parameters:
- BW_in, 8, width of signed input sample (FIR y_out).
- LOG2_DECIM, 2, decimation factor DECIM = 2^LOG2_DECIM; legal range 1..3.
- SHIFT, 1, arithmetic right shift applied to block sum before saturation; legal range 0..LOG2_DECIM.
- BW_out, 8, width of signed output result.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, 2..8.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, y_in holds a valid FIR sample this cycle.
- y_in, input, BW_in, signed FIR output sample.
- sync, input, 1, discard the partial block and restart block phase.
- out_valid, output, 1, FIFO non-empty; out_data valid.
- out_ready, input, 1, consumer accepts out_data this cycle.
- out_data, output, BW_out, signed decimated result at FIFO head.
- fifo_level, output, 4, number of FIFO entries (0..FIFO_DEPTH).
- saturated, output, 1, sticky: at least one result clipped.
- overrun, output, 1, sticky: at least one result dropped because the FIFO was full.

Behaviour:
- Accumulator acc is signed, BW_acc = BW_in + LOG2_DECIM bits; it never overflows internally. Phase counter cnt runs 0..DECIM-1.
- Reset has priority over everything. acc=0, cnt=0, FIFO emptied (pointers 0), out_valid=0, out_data=0, fifo_level=0, saturated=0, overrun=0.
- If sync=1 (and reset=0), then acc<=0 and cnt<=0. in_valid in the same cycle is ignored. FIFO, flags and the pop side are unaffected.
- in_valid=1 with cnt<DECIM-1: acc<=acc+y_in (sign-extended), cnt<=cnt+1.
- in_valid=1 with cnt==DECIM-1 is a dump:
  - s=(acc+y_in)>>>SHIFT.
  - r=s clipped to [-2^(BW_out-1), 2^(BW_out-1)-1]; saturated<=1 if clipped.
  - Push r; acc<=0, cnt<=0.
- in_valid=0: acc and cnt hold.
- Pop when out_valid && out_ready; the head advances at the next edge. out_data always shows the current head; it is 0 when empty.
- Push when not full: the entry is written and out_valid=1 on the next cycle if the FIFO was empty. Latency from dump edge to out_valid is 1 cycle; there is no combinational bypass.
- Push when full and no pop in the same cycle: the result is dropped, overrun<=1, FIFO unchanged.
- Push when full with a pop in the same cycle: both occur, the level stays FIFO_DEPTH, and there is no overrun.
- Push and pop when non-empty and not full: the level is unchanged.
- Pop when empty: no effect.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is registered and consistent with out_valid (out_valid = level!=0).
- saturated and overrun are cleared only by reset.

Test Plan:
- Defaults, out_ready=1. in_valid with 10,20,30,40 gives out_valid one cycle after the 4th sample, out_data=50, then pops. Next block -5,-5,-5,-6 gives out_data=-11 (-21>>>1), saturated=0.
- Saturation. Four samples of 127 (sum 508>>>1=254) give out_data=127, saturated=1. Four of -128 give -128. Saturated stays 1 through later unclipped blocks.
- Backpressure and overrun, out_ready=0:
  - Five blocks of 4,4,4,4 (result 8) give fifo_level=4, overrun=1, and exactly four results of 8 drained after out_ready=1.
  - Repeat with out_ready=1 held in the 5th dump cycle: no overrun, level stays 4.
- sync mid-block. Samples 100,100, then sync=1 with in_valid=1, y_in=100, then 1,2,3,4. Only one result is produced: 5 (10>>>1). Earlier samples and the sync-cycle sample are discarded.
- Reset mid-operation. Two results queued, one partial sample in acc, flags set; reset=1 for one cycle. Next cycle: fifo_level=0, out_valid=0, flags 0. The following 4-sample block is accumulated from zero.
- Wrap-around. Continuous input with out_ready toggling 1/0 for 40 blocks; outputs match a reference model in order with no loss, and pointers wrap several times.
